// File: rtl/alu_pc_unit_if.sv
// Bus bundle for the ALU / PC unit: PC update, instruction fields, operands and results.
// Latency: carries combinational ALU/branch signals and the registered PC output.
// Backpressure: none; clk_enable is the only flow control and it only gates the PC.
interface alu_pc_unit_if;
    logic        clk_enable;
    logic [31:0] PCin;
    logic [31:0] PCout;
    logic [5:0]  opcode;
    logic [5:0]  functcode;
    logic [4:0]  shamt;
    logic [4:0]  rt_instr;
    logic [15:0] immediate;
    logic [31:0] rs_content;
    logic [31:0] rt_content;
    logic [31:0] ALU_result;
    logic        sig_branch;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] PCplus4;
    logic [31:0] extendImm;
    logic [31:0] Add_ALUresult;

    // Driver side: supplies instruction, operands and PC input; observes results.
    modport master (
        output clk_enable, PCin, opcode, functcode, shamt, rt_instr, immediate,
               rs_content, rt_content, PCplus4, extendImm,
        input  PCout, ALU_result, sig_branch, HI, LO, Add_ALUresult
    );

    // Unit side.
    modport slave (
        input  clk_enable, PCin, opcode, functcode, shamt, rt_instr, immediate,
               rs_content, rt_content, PCplus4, extendImm,
        output PCout, ALU_result, sig_branch, HI, LO, Add_ALUresult
    );
endinterface

// File: rtl/alu_pc_unit.sv
// MIPS-style PC register plus combinational ALU, HI/LO producer, branch test and branch adder.
// Latency: PC updates one cycle after PCin with clk_enable; all other outputs are combinational.
// Backpressure: none; clk_enable=0 holds the PC, the ALU ignores it.
module alu_pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
    input  logic         clk,
    input  logic         reset,
    alu_pc_unit_if.slave bus
);
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] simm;
    logic [31:0] zimm;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] quot_u;
    logic [31:0] rem_u;
    logic [31:0] pc_q;
    logic [31:0] alu_res;
    logic [31:0] hi_res;
    logic [31:0] lo_res;
    logic        br_res;

    assign rs   = bus.rs_content;
    assign rt   = bus.rt_content;
    assign simm = {{16{bus.immediate[15]}}, bus.immediate};
    assign zimm = {16'h0000, bus.immediate};

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign prod_u = {32'h0, rs} * {32'h0, rt};
    assign quot_s = $signed(rs) / $signed(rt);
    assign rem_s  = $signed(rs) % $signed(rt);
    assign quot_u = rs / rt;
    assign rem_u  = rs % rt;

    // PC register: reset wins over enable; otherwise load PCin only when enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_VECTOR;
        end else if (bus.clk_enable) begin
            pc_q <= bus.PCin;
        end
    end

    // Main ALU result; anything not decoded below yields zero.
    always_comb begin
        alu_res = 32'h0;
        if (bus.opcode == 6'h00) begin
            case (bus.functcode)
                6'h00: alu_res = rt << bus.shamt;
                6'h02: alu_res = rt >> bus.shamt;
                6'h03: alu_res = $signed(rt) >>> bus.shamt;
                6'h04: alu_res = rt << rs[4:0];
                6'h06: alu_res = rt >> rs[4:0];
                6'h07: alu_res = $signed(rt) >>> rs[4:0];
                6'h21: alu_res = rs + rt;
                6'h23: alu_res = rs - rt;
                6'h24: alu_res = rs & rt;
                6'h25: alu_res = rs | rt;
                6'h26: alu_res = rs ^ rt;
                6'h27: alu_res = ~(rs | rt);
                6'h2A: alu_res = {31'h0, $signed(rs) < $signed(rt)};
                6'h2B: alu_res = {31'h0, rs < rt};
                default: alu_res = 32'h0;
            endcase
        end else begin
            case (bus.opcode)
                6'h09: alu_res = rs + simm;
                6'h0A: alu_res = {31'h0, $signed(rs) < $signed(simm)};
                6'h0B: alu_res = {31'h0, rs < simm};
                6'h0C: alu_res = rs & zimm;
                6'h0D: alu_res = rs | zimm;
                6'h0E: alu_res = rs ^ zimm;
                6'h0F: alu_res = {bus.immediate, 16'h0000};
                6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                6'h28, 6'h29, 6'h2B: alu_res = rs + simm;
                default: alu_res = 32'h0;
            endcase
        end
    end

    // HI/LO values; the register write enables live outside this block.
    always_comb begin
        hi_res = 32'h0;
        lo_res = 32'h0;
        if (bus.opcode == 6'h00) begin
            case (bus.functcode)
                6'h11: hi_res = rs;
                6'h13: lo_res = rs;
                6'h18: {hi_res, lo_res} = prod_s;
                6'h19: {hi_res, lo_res} = prod_u;
                6'h1A: begin
                    if (rt != 32'h0) begin
                        hi_res = rem_s;
                        lo_res = quot_s;
                    end
                end
                6'h1B: begin
                    if (rt != 32'h0) begin
                        hi_res = rem_u;
                        lo_res = quot_u;
                    end
                end
                default: begin
                    hi_res = 32'h0;
                    lo_res = 32'h0;
                end
            endcase
        end
    end

    // Branch condition, including the REGIMM group selected by the rt field.
    always_comb begin
        br_res = 1'b0;
        case (bus.opcode)
            6'h04: br_res = (rs == rt);
            6'h05: br_res = (rs != rt);
            6'h06: br_res = rs[31] || (rs == 32'h0);
            6'h07: br_res = !rs[31] && (rs != 32'h0);
            6'h01: begin
                case (bus.rt_instr)
                    5'd0, 5'd16: br_res = rs[31];
                    5'd1, 5'd17: br_res = !rs[31];
                    default:     br_res = 1'b0;
                endcase
            end
            default: br_res = 1'b0;
        endcase
    end

    assign bus.PCout         = pc_q;
    assign bus.ALU_result    = alu_res;
    assign bus.HI            = hi_res;
    assign bus.LO            = lo_res;
    assign bus.sig_branch    = br_res;
    assign bus.Add_ALUresult = bus.PCplus4 + bus.extendImm;
endmodule

// File: tb/tb_alu_pc_unit.sv
// Bench for alu_pc_unit: directed vector table, PC sequences, and randomized ALU/PC checks.
// Latency: combinational outputs sampled 1 time unit after inputs settle; PC sampled after the edge.
// Backpressure: none involved.
module tb_alu_pc_unit;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    alu_pc_unit_if bus ();

    alu_pc_unit #(.RESET_VECTOR(32'hBFC0_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  sh;
        logic [4:0]  rti;
        logic [15:0] imm;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] alu;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        br;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [4:0] rti, input logic [15:0] imm,
                         input logic [31:0] rs, input logic [31:0] rt);
        bus.opcode     = op;
        bus.functcode  = fn;
        bus.shamt      = sh;
        bus.rt_instr   = rti;
        bus.immediate  = imm;
        bus.rs_content = rs;
        bus.rt_content = rt;
        #1;
    endtask

    // Reference: instruction semantics written with plain integer arithmetic.
    function automatic void ref_model(input logic [5:0] op, input logic [5:0] fn,
                                      input logic [4:0] sh, input logic [4:0] rti,
                                      input logic [15:0] imm, input logic [31:0] rs,
                                      input logic [31:0] rt, output logic [31:0] alu,
                                      output logic [31:0] hi, output logic [31:0] lo,
                                      output logic br);
        int a;
        int b;
        int si;
        longint p;
        longint unsigned pu;
        logic [31:0] simm;
        a    = rs;
        b    = rt;
        simm = {{16{imm[15]}}, imm};
        si   = simm;
        alu  = 32'h0;
        hi   = 32'h0;
        lo   = 32'h0;
        br   = 1'b0;
        if (op == 6'h00) begin
            case (fn)
                6'h00: alu = rt << sh;
                6'h02: alu = rt >> sh;
                6'h03: alu = b >>> sh;
                6'h04: alu = rt << (rs % 32);
                6'h06: alu = rt >> (rs % 32);
                6'h07: alu = b >>> (rs % 32);
                6'h21: alu = rs + rt;
                6'h23: alu = rs - rt;
                6'h24: alu = rs & rt;
                6'h25: alu = rs | rt;
                6'h26: alu = rs ^ rt;
                6'h27: alu = ~(rs | rt);
                6'h2A: alu = (a < b) ? 32'd1 : 32'd0;
                6'h2B: alu = (rs < rt) ? 32'd1 : 32'd0;
                6'h11: hi = rs;
                6'h13: lo = rs;
                6'h18: begin
                    p  = longint'(a) * longint'(b);
                    hi = p[63:32];
                    lo = p[31:0];
                end
                6'h19: begin
                    pu = longint'(rs) * longint'(rt);
                    hi = pu[63:32];
                    lo = pu[31:0];
                end
                6'h1A: if (b != 0) begin lo = a / b; hi = a % b; end
                6'h1B: if (rt != 0) begin lo = rs / rt; hi = rs % rt; end
                default: ;
            endcase
        end else begin
            case (op)
                6'h09: alu = rs + simm;
                6'h0A: alu = (a < si) ? 32'd1 : 32'd0;
                6'h0B: alu = (rs < simm) ? 32'd1 : 32'd0;
                6'h0C: alu = rs & {16'h0, imm};
                6'h0D: alu = rs | {16'h0, imm};
                6'h0E: alu = rs ^ {16'h0, imm};
                6'h0F: alu = {imm, 16'h0};
                6'h04: br = (rs == rt);
                6'h05: br = (rs != rt);
                6'h06: br = (a <= 0);
                6'h07: br = (a > 0);
                6'h01: begin
                    if (rti == 0 || rti == 16)      br = (a < 0);
                    else if (rti == 1 || rti == 17) br = (a >= 0);
                end
                default: if (op inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                        6'h28, 6'h29, 6'h2B}) alu = rs + simm;
            endcase
        end
    endfunction

    initial begin
        logic [31:0] e_alu;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        logic        e_br;
        logic [31:0] pc_model;
        logic [5:0]  ops [16];
        logic [5:0]  fns [24];
        tests = 0;
        fails = 0;

        //            op     fn     sh  rti  imm       rs            rt            alu           hi            lo            br
        vecs[0]  = '{6'h00, 6'h21, 5'd0, 5'd0,  16'h0,    32'hFFFFFFFF, 32'h1,        32'h0,        32'h0,        32'h0,        1'b0};
        vecs[1]  = '{6'h00, 6'h2A, 5'd0, 5'd0,  16'h0,    32'hFFFFFFFF, 32'h1,        32'h1,        32'h0,        32'h0,        1'b0};
        vecs[2]  = '{6'h00, 6'h2B, 5'd0, 5'd0,  16'h0,    32'hFFFFFFFF, 32'h1,        32'h0,        32'h0,        32'h0,        1'b0};
        vecs[3]  = '{6'h00, 6'h03, 5'd4, 5'd0,  16'h0,    32'h0,        32'h80000000, 32'hF8000000, 32'h0,        32'h0,        1'b0};
        vecs[4]  = '{6'h00, 6'h18, 5'd0, 5'd0,  16'h0,    32'hFFFFFFFE, 32'h3,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
        vecs[5]  = '{6'h00, 6'h19, 5'd0, 5'd0,  16'h0,    32'hFFFFFFFE, 32'h3,        32'h0,        32'h2,        32'hFFFFFFFA, 1'b0};
        vecs[6]  = '{6'h00, 6'h1A, 5'd0, 5'd0,  16'h0,    32'hFFFFFFF9, 32'h2,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[7]  = '{6'h00, 6'h1B, 5'd0, 5'd0,  16'h0,    32'h1234,     32'h0,        32'h0,        32'h0,        32'h0,        1'b0};
        vecs[8]  = '{6'h04, 6'h00, 5'd0, 5'd0,  16'h0,    32'h5,        32'h5,        32'h0,        32'h0,        32'h0,        1'b1};
        vecs[9]  = '{6'h01, 6'h00, 5'd0, 5'd1,  16'h0,    32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        1'b1};
        vecs[10] = '{6'h01, 6'h00, 5'd0, 5'd16, 16'h0,    32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        1'b0};
        vecs[11] = '{6'h07, 6'h00, 5'd0, 5'd0,  16'h0,    32'h80000000, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0};
        vecs[12] = '{6'h23, 6'h00, 5'd0, 5'd0,  16'hFFFC, 32'h1000,     32'h0,        32'h00000FFC, 32'h0,        32'h0,        1'b0};
        vecs[13] = '{6'h0F, 6'h00, 5'd0, 5'd0,  16'h1234, 32'h0,        32'h0,        32'h12340000, 32'h0,        32'h0,        1'b0};
        vecs[14] = '{6'h0D, 6'h00, 5'd0, 5'd0,  16'h8000, 32'hA5A51234, 32'h0,        32'hA5A59234, 32'h0,        32'h0,        1'b0};
        vecs[15] = '{6'h00, 6'h11, 5'd0, 5'd0,  16'h0,    32'hDEADBEEF, 32'h7,        32'h0,        32'hDEADBEEF, 32'h0,        1'b0};
        vecs[16] = '{6'h00, 6'h08, 5'd0, 5'd0,  16'h0,    32'h1234,     32'h9,        32'h0,        32'h0,        32'h0,        1'b0};
        vecs[17] = '{6'h00, 6'h04, 5'd0, 5'd0,  16'h0,    32'h24,       32'h1,        32'h10,       32'h0,        32'h0,        1'b0};

        reset          = 1'b1;
        bus.clk_enable = 1'b0;
        bus.PCin       = 32'h0;
        bus.PCplus4    = 32'h0;
        bus.extendImm  = 32'h0;
        apply(6'h0, 6'h0, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0);

        // PC: reset taken with enable low, then load, then hold.
        @(posedge clk); #1;
        check32("pc_reset_ce0", bus.PCout, 32'hBFC00000);
        reset = 1'b0; bus.clk_enable = 1'b1; bus.PCin = 32'h10;
        @(posedge clk); #1;
        check32("pc_load", bus.PCout, 32'h10);
        bus.clk_enable = 1'b0; bus.PCin = 32'h20;
        @(posedge clk); #1;
        check32("pc_hold", bus.PCout, 32'h10);
        reset = 1'b1; bus.clk_enable = 1'b1;
        @(posedge clk); #1;
        check32("pc_reset_ce1", bus.PCout, 32'hBFC00000);
        reset = 1'b0;

        // Branch adder, including wrap-around.
        bus.PCplus4 = 32'hBFC00004; bus.extendImm = 32'hFFFFFFF8; #1;
        check32("add_alu", bus.Add_ALUresult, 32'hBFBFFFFC);
        bus.PCplus4 = 32'hFFFFFFFC; bus.extendImm = 32'h8; #1;
        check32("add_alu_wrap", bus.Add_ALUresult, 32'h4);

        // Directed vector table; clk_enable toggled to show it has no effect.
        for (int i = 0; i < NV; i++) begin
            bus.clk_enable = i[0];
            apply(vecs[i].op, vecs[i].fn, vecs[i].sh, vecs[i].rti, vecs[i].imm, vecs[i].rs, vecs[i].rt);
            check32($sformatf("vec%0d.alu", i), bus.ALU_result, vecs[i].alu);
            check32($sformatf("vec%0d.hi", i), bus.HI, vecs[i].hi);
            check32($sformatf("vec%0d.lo", i), bus.LO, vecs[i].lo);
            check32($sformatf("vec%0d.br", i), {31'h0, bus.sig_branch}, {31'h0, vecs[i].br});
        end

        // Randomized ALU checks against the reference model.
        ops = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h01, 6'h04, 6'h05, 6'h06,
                6'h07, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0F, 6'h23, 6'h02};
        fns = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h10,
                6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h20,
                6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
        for (int i = 0; i < 400; i++) begin
            logic [5:0]  op;
            logic [5:0]  fn;
            logic [4:0]  sh;
            logic [4:0]  rti;
            logic [15:0] imm;
            logic [31:0] rs;
            logic [31:0] rt;
            op  = ops[$urandom_range(0, 15)];
            fn  = fns[$urandom_range(0, 23)];
            sh  = 5'($urandom);
            rti = 5'($urandom);
            imm = 16'($urandom);
            rs  = $urandom;
            rt  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 5) == 0) rt = rs;
            if (rs == 32'h80000000 && rt == 32'hFFFFFFFF) rt = 32'h1;
            apply(op, fn, sh, rti, imm, rs, rt);
            ref_model(op, fn, sh, rti, imm, rs, rt, e_alu, e_hi, e_lo, e_br);
            check32($sformatf("rnd%0d.alu op%02h fn%02h", i, op, fn), bus.ALU_result, e_alu);
            check32($sformatf("rnd%0d.hi op%02h fn%02h", i, op, fn), bus.HI, e_hi);
            check32($sformatf("rnd%0d.lo op%02h fn%02h", i, op, fn), bus.LO, e_lo);
            check32($sformatf("rnd%0d.br op%02h rt%0d", i, op, rti), {31'h0, bus.sig_branch}, {31'h0, e_br});
        end

        // Randomized PC sequence with occasional reset.
        pc_model = 32'hBFC00000;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            reset          = ($urandom_range(0, 9) == 0);
            bus.clk_enable = 1'($urandom);
            bus.PCin       = $urandom;
            if (reset)               pc_model = 32'hBFC00000;
            else if (bus.clk_enable) pc_model = bus.PCin;
            @(posedge clk); #1;
            check32($sformatf("pc_rnd%0d", i), bus.PCout, pc_model);
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_pc_unit.md
ALU_PC_UNIT -- requirements
Module: alu_pc_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'hBFC0_0000; PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1; single clock, all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1; synchronous, active-high.
REQ-004 SHALL have port clk_enable, input, 1; PC update enable.
REQ-005 SHALL have port PCin, input, 32; next PC value.
REQ-006 SHALL have port PCout, output, 32; current PC, registered.
REQ-007 SHALL have ports opcode (6), functcode (6), shamt (5), rt_instr (5), immediate (16), all inputs; instruction fields.
REQ-008 SHALL have ports rs_content and rt_content, input, 32 each; register operands.
REQ-009 SHALL have port ALU_result, output, 32; combinational result or memory address.
REQ-010 SHALL have port sig_branch, output, 1; branch condition taken.
REQ-011 SHALL have ports HI and LO, output, 32 each; combinational values for the HI/LO registers.
REQ-012 SHALL have ports PCplus4 and extendImm, input, 32 each; branch adder operands.
REQ-013 SHALL have port Add_ALUresult, output, 32; branch target.

Function
REQ-014 PC SHALL load PCin on a rising edge when clk_enable=1 and reset=0, and SHALL hold otherwise.
REQ-015 Add_ALUresult SHALL be PCplus4+extendImm, combinational, modulo 2^32.
REQ-016 The ALU SHALL be purely combinational; clk_enable SHALL NOT affect it.
REQ-017 For opcode 0 the ALU SHALL compute: SLL/SRL/SRA by shamt; SLLV/SRLV/SRAV by rs[4:0] on rt; ADDU/SUBU (rs±rt, no overflow trap); AND/OR/XOR/NOR; SLT (signed) and SLTU (unsigned), giving 1 or 0.
REQ-018 Immediate ops SHALL compute: ADDIU/SLTI/SLTIU with sign-extended immediate (SLTIU compares unsigned after sign extension); ANDI/ORI/XORI with zero-extended immediate; LUI gives {immediate,16'h0}.
REQ-019 Loads and stores (opcodes 0x20-0x26, 0x28, 0x29, 0x2B) SHALL output ALU_result = rs + sign-extended immediate.
REQ-020 MULT/MULTU SHALL output the signed/unsigned 64-bit product as {HI,LO}.
REQ-021 DIV/DIVU SHALL output LO=quotient and HI=remainder, signed/unsigned; signed division truncates toward zero and the remainder takes the dividend's sign.
REQ-022 On division by zero, HI and LO SHALL be 0.
REQ-023 MTHI SHALL output HI=rs; MTLO SHALL output LO=rs.
REQ-024 For all other instructions, HI and LO SHALL be 0; write-enables are external.
REQ-025 sig_branch SHALL be: BEQ rs==rt; BNE rs!=rt; BLEZ rs<=0 signed; BGTZ rs>0.
REQ-026 For opcode 1, sig_branch SHALL be: rt_instr 0 or 16 (BLTZ/BLTZAL) rs<0; rt_instr 1 or 17 (BGEZ/BGEZAL) rs>=0.
REQ-027 sig_branch SHALL be 0 for every other instruction.
REQ-028 ALU_result SHALL be 0 for unlisted opcode/funct combinations, including JR, JALR, MFHI, MFLO, J and JAL.

Reset
REQ-029 When reset=1 at a rising edge, PCout SHALL become RESET_VECTOR regardless of clk_enable.
REQ-030 A reset asserted while clk_enable=0 SHALL still load RESET_VECTOR.
REQ-031 The combinational outputs SHALL have no reset state and SHALL depend only on current inputs.

Verification
REQ-032 reset=1 for one edge, then clk_enable=1, PCin=32'h0000_0010 -> PCout=BFC00000 after the reset edge, then 00000010 after the next edge; with clk_enable=0 and PCin=32'h20, PCout stays 00000010.
REQ-033 ADDU rs=FFFFFFFF, rt=1 -> ALU_result=0; SLT rs=FFFFFFFF, rt=1 -> 1; SLTU with the same operands -> 0; SRA shamt=4, rt=80000000 -> F8000000.
REQ-034 MULT rs=FFFFFFFE (-2), rt=3 -> HI=FFFFFFFF, LO=FFFFFFFA; MULTU with the same operands -> HI=2, LO=FFFFFFFA; DIV rs=-7, rt=2 -> LO=FFFFFFFD, HI=FFFFFFFF; DIVU with rt=0 -> HI=LO=0.
REQ-035 BEQ rs=rt=5 -> sig_branch=1; BGEZ rs=0 -> 1; BLTZAL rs=0 -> 0; BGTZ rs=80000000 -> 0.
REQ-036 LW rs=1000, immediate=FFFC -> ALU_result=00000FFC; LUI immediate=1234 -> 12340000; ORI immediate=8000 -> bits[15:0] ORed with 8000 and bits[31:16] unchanged.
REQ-037 Add_ALU with PCplus4=BFC00004 and extendImm=FFFFFFF8 -> Add_ALUresult=BFBFFFFC.
